// File: rtl/puf_uart_pkg.sv
`default_nettype none
// ============================================================================
// puf_uart_pkg : shared state encoding, response codes and default timeouts
// Rev 1.0
// ============================================================================
package puf_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COLLECT    = 3'd1,
        ST_EVAL       = 3'd2,
        ST_SEND       = 3'd3,
        ST_WAIT_TX_HI = 3'd4,
        ST_WAIT_TX_LO = 3'd5
    } state_e;

    localparam logic [7:0]  C_ASCII_ZERO         = 8'h30;
    localparam logic [7:0]  C_TIMEOUT_CODE       = 8'hEE;
    localparam int unsigned C_DEFAULT_BYTE_TIMEOUT = 100000;
    localparam int unsigned C_DEFAULT_PUF_TIMEOUT  = 1024;
    localparam int          C_IDX_W              = 5;

endpackage
`default_nettype wire

// File: rtl/puf_timeout_counter.sv
`default_nettype none
// ============================================================================
// puf_timeout_counter : saturating up-counter with clear, enable, terminal count
// Rev 1.0
// ============================================================================
module puf_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int C_CNT_W = $clog2(LIMIT + 1);

    logic [C_CNT_W-1:0] count_q;

    // Saturates at LIMIT so terminal count stays asserted until cleared
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !tc_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == C_CNT_W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/puf_uart_sequencer.sv
`default_nettype none
// ============================================================================
// puf_uart_sequencer : collects a UART challenge frame, runs the PUF, sends bit
// Rev 1.0
// ============================================================================
module puf_uart_sequencer
    import puf_uart_pkg::*;
#(
    parameter int unsigned CHAL_BYTES   = 8,
    parameter int unsigned BYTE_TIMEOUT = C_DEFAULT_BYTE_TIMEOUT,
    parameter int unsigned PUF_TIMEOUT  = C_DEFAULT_PUF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    received,
    input  logic [7:0]              rx_byte,
    input  logic                    recv_error,
    input  logic                    is_transmitting,
    output logic                    transmit,
    output logic [7:0]              tx_byte,
    output logic [8*CHAL_BYTES-1:0] challenge,
    output logic                    puf_start,
    input  logic                    puf_done,
    input  logic                    puf_response,
    output logic                    busy,
    output logic                    frame_error,
    output logic [7:0]              display_byte
);

    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(CHAL_BYTES - 1);

    state_e                  state_q,       state_d;
    logic [C_IDX_W-1:0]      idx_q,         idx_d;
    logic [8*CHAL_BYTES-1:0] challenge_q,   challenge_d;
    logic [7:0]              tx_byte_q,     tx_byte_d;
    logic                    transmit_q,    transmit_d;
    logic                    puf_start_q,   puf_start_d;
    logic                    frame_error_q, frame_error_d;
    logic [7:0]              display_q,     display_d;

    logic w_byte_tc;
    logic w_puf_tc;
    logic w_store;

    puf_timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q != ST_COLLECT) || received),
        .enable_i (state_q == ST_COLLECT),
        .tc_o     (w_byte_tc)
    );

    puf_timeout_counter #(.LIMIT(PUF_TIMEOUT)) u_puf_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != ST_EVAL),
        .enable_i (state_q == ST_EVAL),
        .tc_o     (w_puf_tc)
    );

    assign w_store = received && !recv_error &&
                     ((state_q == ST_IDLE) || (state_q == ST_COLLECT));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        challenge_d   = challenge_q;
        tx_byte_d     = tx_byte_q;
        transmit_d    = 1'b0;
        frame_error_d = frame_error_q;
        display_d     = received ? rx_byte : display_q;

        if (w_store) begin
            for (int k = 0; k < int'(CHAL_BYTES); k++) begin
                if (idx_q == C_IDX_W'(k)) begin
                    challenge_d[8*k +: 8] = rx_byte;
                end
            end
            idx_d = idx_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (recv_error) begin
                    frame_error_d = 1'b1;
                end else if (received) begin
                    frame_error_d = 1'b0;
                    state_d       = (idx_q == C_LAST_IDX) ? ST_EVAL : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (recv_error || (!received && w_byte_tc)) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (received && (idx_q == C_LAST_IDX)) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (puf_done) begin
                    tx_byte_d = C_ASCII_ZERO | {7'd0, puf_response};
                    state_d   = ST_SEND;
                end else if (w_puf_tc) begin
                    tx_byte_d     = C_TIMEOUT_CODE;
                    frame_error_d = 1'b1;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    state_d    = ST_WAIT_TX_HI;
                end
            end
            ST_WAIT_TX_HI: begin
                if (is_transmitting) begin
                    state_d = ST_WAIT_TX_LO;
                end
            end
            ST_WAIT_TX_LO: begin
                if (!is_transmitting) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A discarded or finished frame always restarts at byte 0
        if (state_d == ST_IDLE) begin
            idx_d = '0;
        end

        puf_start_d = (state_d == ST_EVAL) && (state_q != ST_EVAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            challenge_q   <= '0;
            tx_byte_q     <= 8'h00;
            transmit_q    <= 1'b0;
            puf_start_q   <= 1'b0;
            frame_error_q <= 1'b0;
            display_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            challenge_q   <= challenge_d;
            tx_byte_q     <= tx_byte_d;
            transmit_q    <= transmit_d;
            puf_start_q   <= puf_start_d;
            frame_error_q <= frame_error_d;
            display_q     <= display_d;
        end
    end

    assign transmit     = transmit_q;
    assign tx_byte      = tx_byte_q;
    assign challenge    = challenge_q;
    assign puf_start    = puf_start_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_error  = frame_error_q;
    assign display_byte = display_q;

endmodule
`default_nettype wire
